// File: rtl/mmcm_ps_pkg.sv
// Shared types and defaults for the MMCM dynamic phase-shift sequencer.
package mmcm_ps_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        GAP
    } ps_state_t;

    localparam int unsigned PS_DONE_TMO_DEFAULT = 64;

endpackage

// File: rtl/ps_step_timer.sv
// Loadable down-counter with zero flag; time-shared by the GAP wait and the PSDONE timeout.
module ps_step_timer #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         reset_in_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge reset_in_n) begin
        if (!reset_in_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mmcm_ps_sequencer.sv
// Issues one PSEN per requested phase step, paced by PSDONE and an optional idle gap,
// tracking net acknowledged phase and flagging PSDONE timeouts or spurious PSDONE.
module mmcm_ps_sequencer
    import mmcm_ps_pkg::*;
#(
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned GAP_W    = 32,
    parameter int unsigned POS_W    = 32,
    parameter int unsigned DONE_TMO = PS_DONE_TMO_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_in_n,
    input  logic             enable,
    input  logic             mmcm_locked,
    input  logic             cmd_valid,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic [GAP_W-1:0] cmd_gap,
    output logic             cmd_ready,
    input  logic             abort,
    input  logic             err_clear,
    output logic             psen,
    output logic             psincdec,
    input  logic             psdone,
    output logic             busy,
    output logic             cmd_done,
    output logic             cmd_err,
    output logic [POS_W-1:0] position,
    output logic             timeout_err,
    output logic             spurious_done
);

    // Timer runs through WAIT_DONE cycles psen+1 .. psen+DONE_TMO-1; expiry sits on the last one.
    localparam logic [GAP_W-1:0] TMO_LOAD = GAP_W'(DONE_TMO - 2);

    ps_state_t        state, state_next;
    logic [CNT_W-1:0] rem;
    logic [CNT_W-1:0] cmd_mag;
    logic [GAP_W-1:0] gap;
    logic [GAP_W-1:0] tmr_load_val;
    logic             tmr_load, tmr_dec, tmr_zero;
    logic             accept, step_ack, finish, tmo, done_next, stop_req;

    assign cmd_ready = (state == IDLE) && enable && mmcm_locked;
    assign psen      = (state == ISSUE);
    assign busy      = (state != IDLE);
    assign stop_req  = abort || !mmcm_locked;
    assign cmd_mag   = cmd_steps[CNT_W-1] ? ('0 - cmd_steps) : cmd_steps;

    ps_step_timer #(
        .W (GAP_W)
    ) u_timer (
        .clk        (clk),
        .reset_in_n (reset_in_n),
        .load       (tmr_load),
        .load_val   (tmr_load_val),
        .dec        (tmr_dec),
        .zero       (tmr_zero)
    );

    always_ff @(posedge clk or negedge reset_in_n) begin
        if (!reset_in_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        accept       = 1'b0;
        step_ack     = 1'b0;
        finish       = 1'b0;
        tmo          = 1'b0;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        tmr_dec      = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    accept = 1'b1;
                    if (cmd_mag != '0) begin
                        state_next = ISSUE;
                    end
                end
            end
            ISSUE: begin
                tmr_load     = 1'b1;
                tmr_load_val = TMO_LOAD;
                state_next   = WAIT_DONE;
            end
            WAIT_DONE: begin
                // psdone is checked before expiry so a coincident acknowledge still counts
                if (psdone) begin
                    step_ack = 1'b1;
                    if ((rem == CNT_W'(1)) || stop_req) begin
                        finish     = 1'b1;
                        state_next = IDLE;
                    end else if (gap == '0) begin
                        state_next = ISSUE;
                    end else begin
                        tmr_load     = 1'b1;
                        tmr_load_val = gap - GAP_W'(1);
                        state_next   = GAP;
                    end
                end else if (tmr_zero) begin
                    tmo        = 1'b1;
                    finish     = 1'b1;
                    state_next = IDLE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            GAP: begin
                if (stop_req) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end else if (tmr_zero) begin
                    state_next = ISSUE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        done_next = finish || (accept && (cmd_mag == '0));
    end

    always_ff @(posedge clk or negedge reset_in_n) begin
        if (!reset_in_n) begin
            psincdec      <= 1'b0;
            rem           <= '0;
            gap           <= '0;
            position      <= '0;
            cmd_done      <= 1'b0;
            cmd_err       <= 1'b0;
            timeout_err   <= 1'b0;
            spurious_done <= 1'b0;
        end else begin
            cmd_done <= done_next;
            cmd_err  <= tmo;
            if (accept) begin
                rem <= cmd_mag;
                gap <= cmd_gap;
                // A zero-step command leaves the direction line where the last step left it
                if (cmd_mag != '0) begin
                    psincdec <= ~cmd_steps[CNT_W-1];
                end
            end
            if (step_ack) begin
                rem      <= rem - CNT_W'(1);
                position <= psincdec ? (position + POS_W'(1)) : (position - POS_W'(1));
            end
            if (tmo) begin
                timeout_err <= 1'b1;
            end else if (err_clear) begin
                timeout_err <= 1'b0;
            end
            if (psdone && (state != WAIT_DONE)) begin
                spurious_done <= 1'b1;
            end else if (err_clear) begin
                spurious_done <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mmcm_ps_sequencer.sv
// Scoreboard bench: commands push expected PSEN/cmd_done events; a monitor pops and compares.
module tb_mmcm_ps_sequencer;

    logic        clk = 1'b0;
    logic        reset_in_n = 1'b0;
    logic        enable = 1'b1;
    logic        mmcm_locked = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [31:0] cmd_steps = '0;
    logic [31:0] cmd_gap = '0;
    logic        cmd_ready;
    logic        abort = 1'b0;
    logic        err_clear = 1'b0;
    logic        psen, psincdec, psdone, busy, cmd_done, cmd_err;
    logic [31:0] position;
    logic        timeout_err, spurious_done;
    logic        mm_done = 1'b0;
    logic        spur_done = 1'b0;

    assign psdone = mm_done | spur_done;

    mmcm_ps_sequencer #(
        .CNT_W    (32),
        .GAP_W    (32),
        .POS_W    (32),
        .DONE_TMO (64)
    ) dut (
        .clk           (clk),
        .reset_in_n    (reset_in_n),
        .enable        (enable),
        .mmcm_locked   (mmcm_locked),
        .cmd_valid     (cmd_valid),
        .cmd_steps     (cmd_steps),
        .cmd_gap       (cmd_gap),
        .cmd_ready     (cmd_ready),
        .abort         (abort),
        .err_clear     (err_clear),
        .psen          (psen),
        .psincdec      (psincdec),
        .psdone        (psdone),
        .busy          (busy),
        .cmd_done      (cmd_done),
        .cmd_err       (cmd_err),
        .position      (position),
        .timeout_err   (timeout_err),
        .spurious_done (spurious_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int cyc; logic dir;}          psen_exp_t;
    typedef struct {int cyc; logic err; int pos;} done_exp_t;
    typedef struct {int lat; logic ab;}           mm_t;

    psen_exp_t psen_q[$];
    done_exp_t done_q[$];
    mm_t       mm_q[$];
    int        pos_model = 0;
    int        n_checks = 0;
    int        n_pass = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (reset_in_n) begin
            if (psen) begin
                if (psen_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL psen_unexpected: psen=1 with no step pending (cycle %0d)", cyc);
                end else begin
                    psen_exp_t e;
                    e = psen_q.pop_front();
                    check("psen_cycle", cyc, e.cyc);
                    check("psincdec", psincdec, e.dir);
                end
            end
            if (cmd_done) begin
                if (done_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL cmd_done_unexpected: cmd_done=1 with none pending (cycle %0d)", cyc);
                end else begin
                    done_exp_t d;
                    d = done_q.pop_front();
                    check("cmd_done_cycle", cyc, d.cyc);
                    check("cmd_err", cmd_err, d.err);
                    check("position", $signed(position), d.pos);
                end
            end
        end
    end

    // MMCM model: psdone lat cycles after each psen (lat 0 = never), optional abort with it
    int   sched = -1;
    logic sched_ab = 1'b0;
    always @(negedge clk) begin
        mm_t m;
        mm_done = 1'b0;
        if (!reset_in_n) begin
            sched = -1;
            abort = 1'b0;
        end else begin
            if (cmd_done) abort = 1'b0;
            if (sched == cyc) begin
                mm_done = 1'b1;
                if (sched_ab) abort = 1'b1;
                sched = -1;
            end
            if (psen && (mm_q.size() > 0)) begin
                m = mm_q.pop_front();
                if (m.lat > 0) begin
                    sched    = cyc + m.lat;
                    sched_ab = m.ab;
                end
            end
        end
    end

    task automatic issue_cmd(input int steps, input int gap, input int lat_fix,
                             input int tmo_at, input int abort_at);
        int   n, mag, t, lat, d;
        logic dir;
        bit   got;
        got = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            n_checks++;
            $display("FAIL cmd_ready_wait: cmd_ready stayed 0 (cycle %0d)", cyc);
            return;
        end
        n         = cyc;
        cmd_valid = 1'b1;
        cmd_steps = steps;
        cmd_gap   = gap;
        mag = (steps < 0) ? -steps : steps;
        dir = (steps >= 0);
        if (mag == 0) begin
            done_q.push_back(done_exp_t'{n + 1, 1'b0, pos_model});
        end else begin
            t = n + 1;
            for (int k = 0; k < mag; k++) begin
                lat = (k == tmo_at) ? 0 : ((lat_fix > 0) ? lat_fix : int'($urandom_range(1, 30)));
                psen_q.push_back(psen_exp_t'{t, dir});
                mm_q.push_back(mm_t'{lat, (k == abort_at)});
                if (lat == 0) begin
                    done_q.push_back(done_exp_t'{t + 64, 1'b1, pos_model});
                    break;
                end
                d = t + lat;
                pos_model += dir ? 1 : -1;
                if ((k == mag - 1) || (k == abort_at)) begin
                    done_q.push_back(done_exp_t'{d + 1, 1'b0, pos_model});
                    break;
                end
                t = d + gap + 1;
            end
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_cmd();
        bit ok;
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ((psen_q.size() == 0) && (done_q.size() == 0)) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            $display("FAIL cmd_complete_wait: psen_q=%0d done_q=%0d pending (cycle %0d)",
                     psen_q.size(), done_q.size(), cyc);
            psen_q.delete();
            done_q.delete();
            mm_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_err_clear();
        @(negedge clk);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int steps, gap, mag, tmo_at, abort_at;

        repeat (3) @(negedge clk);
        check("rst_psen", psen, 0);
        check("rst_busy", busy, 0);
        check("rst_cmd_done", cmd_done, 0);
        check("rst_cmd_err", cmd_err, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_spurious_done", spurious_done, 0);
        check("rst_position", position, 0);
        check("rst_psincdec", psincdec, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        reset_in_n = 1'b1;
        repeat (2) @(negedge clk);

        issue_cmd(3, 4, 12, -1, -1);
        wait_cmd();
        issue_cmd(-2, 0, 0, -1, -1);
        wait_cmd();
        issue_cmd(0, 7, 0, -1, -1);
        wait_cmd();

        issue_cmd(1, 3, 5, 0, -1);
        wait_cmd();
        check("timeout_err_set", timeout_err, 1);
        pulse_err_clear();
        #1 check("timeout_err_clear", timeout_err, 0);

        issue_cmd(10, 2, 0, -1, 3);
        wait_cmd();
        issue_cmd(2, 1, 63, -1, -1);
        wait_cmd();

        @(negedge clk);
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        @(negedge clk);
        check("spurious_set", spurious_done, 1);
        check("spurious_position", $signed(position), pos_model);
        pulse_err_clear();
        #1 check("spurious_clear", spurious_done, 0);

        @(negedge clk);
        enable = 1'b0;
        #1 check("ready_disabled", cmd_ready, 0);
        @(negedge clk);
        enable = 1'b1;

        @(negedge clk);
        mmcm_locked = 1'b0;
        #1 check("ready_unlocked", cmd_ready, 0);
        cmd_valid = 1'b1;
        cmd_steps = 5;
        cmd_gap   = 0;
        repeat (20) @(negedge clk);
        check("busy_unlocked", busy, 0);
        cmd_valid   = 1'b0;
        mmcm_locked = 1'b1;
        repeat (2) @(negedge clk);

        for (int r = 0; r < 14; r++) begin
            steps    = int'($urandom_range(0, 12)) - 6;
            gap      = int'($urandom_range(0, 5));
            mag      = (steps < 0) ? -steps : steps;
            tmo_at   = -1;
            abort_at = -1;
            if ((mag > 0) && ($urandom_range(0, 5) == 0)) tmo_at = int'($urandom_range(0, mag - 1));
            else if ((mag > 1) && ($urandom_range(0, 4) == 0)) abort_at = int'($urandom_range(0, mag - 2));
            issue_cmd(steps, gap, 0, tmo_at, abort_at);
            wait_cmd();
        end

        issue_cmd(3, 20, 5, -1, -1);
        repeat (10) @(negedge clk);
        #2 reset_in_n = 1'b0;
        #1;
        check("gap_rst_busy", busy, 0);
        check("gap_rst_psen", psen, 0);
        check("gap_rst_position", position, 0);
        check("gap_rst_psincdec", psincdec, 0);
        check("gap_rst_timeout_err", timeout_err, 0);
        check("gap_rst_cmd_done", cmd_done, 0);
        check("gap_rst_cmd_ready", cmd_ready, 1);
        psen_q.delete();
        done_q.delete();
        mm_q.delete();
        pos_model = 0;
        repeat (2) @(negedge clk);
        reset_in_n = 1'b1;
        repeat (2) @(negedge clk);

        issue_cmd(-3, 1, 0, -1, -1);
        wait_cmd();

        check("psen_q_drained", psen_q.size(), 0);
        check("done_q_drained", done_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
